nibble_mac_seq: RTL and testbench

NIBBLE_MAC_SEQ -- requirements
Module: nibble_mac_seq

---
 rtl/nibble_mac_seq.sv | 149 ++++++++++++++
 tb/tb_nibble_mac_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/nibble_mac_seq.sv
// nibble_mac_seq: nibble-loaded unsigned multiply / multiply-accumulate.
// Operands are shifted in one nibble per command, the product is built with
// a W-cycle shift-add loop, and one accumulator byte at a time is shown on uo_out.
module nibble_mac_seq #(
    parameter int W     = 8,
    parameter int ACC_W = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_LOAD_A = 3'b001;
    localparam logic [2:0] OP_LOAD_B = 3'b010;
    localparam logic [2:0] OP_MAC    = 3'b011;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_CLR    = 3'b101;
    localparam logic [2:0] OP_SEL    = 3'b110;

    typedef enum logic [1:0] {IDLE, MULT, ACCUM} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     a_reg, b_reg, a_work, b_work;
    logic [2*W-1:0]   product;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] acc;
    logic [3:0]       sel;
    logic             mac_op, done, ovf, err;
    logic             strb_prev, armed;

    logic             strb, accept, busy, is_nop;
    logic [2:0]       op;
    logic [3:0]       nib;
    logic [ACC_W:0]   mac_sum;

    // ena and uio_in carry no function in this block
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in};

    assign strb    = ui_in[7];
    assign op      = ui_in[6:4];
    assign nib     = ui_in[3:0];
    // armed stays low after reset until the strobe is seen low, so a strobe
    // held high through reset release is not taken as a new command
    assign accept  = strb & ~strb_prev & armed;
    assign busy    = (state != IDLE);
    assign is_nop  = (op == 3'b000) || (op == 3'b111);
    assign mac_sum = {1'b0, acc} + (ACC_W+1)'(product);

    assign uio_out = {err, ovf, done, busy, 4'b0000};
    assign uio_oe  = 8'hF0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: start on MAC/MUL when idle, W multiply cycles, one accumulate cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (op == OP_MAC || op == OP_MUL)) state_nxt = MULT;
            MULT:    if (cnt == CW'(W-1)) state_nxt = ACCUM;
            ACCUM:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: command execution, shift-add multiply, accumulate, status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            a_work    <= '0;
            b_work    <= '0;
            product   <= '0;
            cnt       <= '0;
            acc       <= '0;
            sel       <= '0;
            mac_op    <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            strb_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            strb_prev <= strb;
            armed     <= armed | ~strb;

            if (accept) begin
                if (busy) begin
                    // commands while busy are dropped; only NOP is harmless
                    if (!is_nop) err <= 1'b1;
                end else begin
                    done <= 1'b0;
                    case (op)
                        OP_LOAD_A: a_reg <= W'({a_reg, nib});
                        OP_LOAD_B: b_reg <= W'({b_reg, nib});
                        OP_MAC, OP_MUL: begin
                            a_work  <= a_reg;
                            b_work  <= b_reg;
                            product <= '0;
                            cnt     <= '0;
                            mac_op  <= (op == OP_MAC);
                        end
                        OP_CLR: begin
                            acc <= '0;
                            ovf <= 1'b0;
                            err <= 1'b0;
                        end
                        OP_SEL:  sel <= nib;
                        default: ;
                    endcase
                end
            end

            if (state == MULT) begin
                if (b_work[cnt])
                    product <= product + ({{W{1'b0}}, a_work} << cnt);
                cnt <= cnt + CW'(1);
            end

            if (state == ACCUM) begin
                if (mac_op) begin
                    acc <= mac_sum[ACC_W-1:0];
                    if (mac_sum[ACC_W]) ovf <= 1'b1;
                end else begin
                    acc <= ACC_W'(product);
                end
                done <= 1'b1;
            end
        end
    end

    // Byte selector; out-of-range selects read as zero
    always_comb begin
        uo_out = 8'h00;
        for (int i = 0; i < ACC_W/8; i++)
            if (int'(sel) == i) uo_out = acc[8*i +: 8];
    end

endmodule

// File: tb/tb_nibble_mac_seq.sv
// Directed bench for nibble_mac_seq: a 24-bit and a 16-bit accumulator
// instance run the same command stream in lockstep.
module tb_nibble_mac_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo16, uio_out16, uio_oe16;

    int checks = 0;
    int errors = 0;
    int nbusy;

    localparam logic [2:0] NOP = 3'b000, LDA = 3'b001, LDB = 3'b010, MAC = 3'b011,
                           MUL = 3'b100, CLR = 3'b101, SEL = 3'b110;

    always #5 clk = ~clk;

    nibble_mac_seq #(.W(8), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe));

    nibble_mac_seq #(.W(8), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo16), .uio_out(uio_out16), .uio_oe(uio_oe16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one-cycle strobe pulse followed by one cycle low
    task automatic cmd(input logic [2:0] op, input logic [3:0] n);
        ui_in = {1'b1, op, n};
        tick();
        ui_in = {1'b0, op, n};
        tick();
    endtask

    // start MAC/MUL and count cycles with busy=1, bounded
    task automatic run_op(input logic [2:0] op, output int nb);
        ui_in = {1'b1, op, 4'h0};
        tick();
        ui_in[7] = 1'b0;
        nb = 0;
        while (uio_out[4] && nb < 40) begin
            nb++;
            tick();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick();
        tick();
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;
        tick();

        // 3 * 5 via MUL
        cmd(LDA, 4'h0); cmd(LDA, 4'h3);
        cmd(LDB, 4'h0); cmd(LDB, 4'h5);
        run_op(MUL, nbusy);
        chk("mul_busy_cycles", nbusy, 9);
        chk("mul_done", uio_out[5], 1'b1);
        chk("mul_result", uo_out, 8'h0F);
        chk("mul_result16", uo16, 8'h0F);

        // FF*FF accumulated twice; 16-bit instance overflows
        cmd(CLR, 4'h0);
        chk("clr_done", uio_out[5], 1'b0);
        chk("clr_acc", uo_out, 8'h00);
        cmd(LDA, 4'hF); cmd(LDA, 4'hF);
        cmd(LDB, 4'hF); cmd(LDB, 4'hF);
        run_op(MAC, nbusy);
        run_op(MAC, nbusy);
        chk("mac_busy_cycles", nbusy, 9);
        chk("mac_b0", uo_out, 8'h02);
        chk("mac_ovf24", uio_out[6], 1'b0);
        chk("mac16_b0", uo16, 8'h02);
        chk("mac16_ovf", uio_out16[6], 1'b1);
        cmd(SEL, 4'h1);
        chk("mac_b1", uo_out, 8'hFC);
        chk("mac16_b1", uo16, 8'hFC);
        chk("sel_while_idle_done", uio_out[5], 1'b0);
        cmd(SEL, 4'h2);
        chk("mac_b2", uo_out, 8'h01);
        chk("mac16_b2_oob", uo16, 8'h00);
        cmd(SEL, 4'h3);
        chk("mac_b3_oob", uo_out, 8'h00);
        cmd(CLR, 4'h0);
        cmd(SEL, 4'h1);
        chk("clr16_b1", uo16, 8'h00);
        chk("clr16_ovf", uio_out16[6], 1'b0);
        cmd(SEL, 4'h0);
        chk("clr16_b0", uo16, 8'h00);

        // held strobe: LOAD_A 1 for 5 cycles shifts once -> A = F1
        ui_in = {1'b1, LDA, 4'h1};
        repeat (5) tick();
        ui_in[7] = 1'b0;
        tick();
        cmd(LDB, 4'h0); cmd(LDB, 4'h1);
        run_op(MUL, nbusy);
        chk("held_strobe_A", uo_out, 8'hF1);

        // LOAD_B during MULT: 0x12 * 0x34 = 0x3A8, err set, B kept
        cmd(LDA, 4'h1); cmd(LDA, 4'h2);
        cmd(LDB, 4'h3); cmd(LDB, 4'h4);
        ui_in = {1'b1, MUL, 4'h0};
        tick();
        ui_in[7] = 1'b0;
        tick();
        cmd(LDB, 4'h9);
        chk("busy_cmd_err", uio_out[7], 1'b1);
        nbusy = 0;
        while (uio_out[4] && nbusy < 40) begin
            nbusy++;
            tick();
        end
        chk("busy_cmd_drain", uio_out[4], 1'b0);
        chk("busy_prod_b0", uo_out, 8'hA8);
        cmd(SEL, 4'h1);
        chk("busy_prod_b1", uo_out, 8'h03);
        cmd(SEL, 4'h0);
        run_op(MUL, nbusy);
        chk("b_unchanged", uo_out, 8'hA8);
        chk("err_sticky", uio_out[7], 1'b1);
        cmd(CLR, 4'h0);
        chk("clr_err", uio_out[7], 1'b0);

        // reset during MULT, with the strobe held high through release
        run_op(MUL, nbusy);
        chk("pre_abort_acc", uo_out, 8'hA8);
        ui_in = {1'b1, MUL, 4'h0};
        tick();
        ui_in[7] = 1'b0;
        repeat (3) tick();
        chk("abort_busy_before", uio_out[4], 1'b1);
        ui_in = {1'b1, MUL, 4'h0};
        rst_n = 1'b0;
        tick();
        chk("abort_busy", uio_out[4], 1'b0);
        chk("abort_uio", uio_out, 8'h00);
        chk("abort_acc", uo_out, 8'h00);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("held_through_reset", uio_out[4], 1'b0);
        ui_in[7] = 1'b0;
        tick();
        cmd(LDA, 4'h0); cmd(LDA, 4'h7);
        cmd(LDB, 4'h0); cmd(LDB, 4'h6);
        run_op(MUL, nbusy);
        chk("post_reset_busy", nbusy, 9);
        chk("post_reset_done", uio_out[5], 1'b1);
        chk("post_reset_result", uo_out, 8'h2A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
